// File: rtl/alu_bitserial_seq_if.sv
// CPU-side Start/Done bundle for alu_bitserial_seq; the abort member exists only
// when ALU_SEQ_ABORT_EN is defined.
interface alu_bitserial_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef ALU_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             invalid;

`ifdef ALU_SEQ_ABORT_EN
    modport master (output start, ctrl, op_a, op_b, abort,
                    input  busy, done, result, carry_out, overflow, zero, invalid);
    modport slave  (input  start, ctrl, op_a, op_b, abort,
                    output busy, done, result, carry_out, overflow, zero, invalid);
`else
    modport master (output start, ctrl, op_a, op_b,
                    input  busy, done, result, carry_out, overflow, zero, invalid);
    modport slave  (input  start, ctrl, op_a, op_b,
                    output busy, done, result, carry_out, overflow, zero, invalid);
`endif
endinterface

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first.
// Optional feature: define ALU_SEQ_ABORT_EN to add an abort input on the CPU bundle.
module alu_bitserial_seq #(
    parameter int WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_bitserial_seq_if.slave  io_cpu,
    output logic                o_slice_a,
    output logic                o_slice_b,
    output logic                o_slice_cin,
    output logic                o_slice_ainvert,
    output logic                o_slice_binvert,
    output logic                o_slice_less,
    output logic [2:0]          o_slice_op,
    input  logic                i_slice_result,
    input  logic                i_slice_carry_out
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLT2, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_set;
    logic [2:0]       r_slice_op;
    logic             r_binv, r_is_slt, r_arith, r_invalid;
    logic [WIDTH-1:0] r_result, r_a_sh, r_b_sh;
    logic             r_carry_out, r_overflow, r_zero;

    logic             w_accept, w_abort, w_last;
    logic [WIDTH-1:0] w_result_nxt;
    logic [2:0]       w_dec_op;
    logic             w_dec_binv, w_dec_slt, w_dec_arith, w_dec_invalid;

    assign w_accept     = ((r_state == S_IDLE) || (r_state == S_DONE)) && io_cpu.start;
    assign w_last       = (r_cnt == LAST);
    assign w_result_nxt = {i_slice_result, r_result[WIDTH-1:1]};
`ifdef ALU_SEQ_ABORT_EN
    assign w_abort      = io_cpu.abort && ((r_state == S_RUN) || (r_state == S_SLT2));
`else
    assign w_abort      = 1'b0;
`endif

    // SUB and SLT both subtract: invert B and seed the carry with 1
    always_comb begin
        w_dec_op      = 3'b000;
        w_dec_binv    = 1'b0;
        w_dec_slt     = 1'b0;
        w_dec_arith   = 1'b0;
        w_dec_invalid = 1'b0;
        case (io_cpu.ctrl)
            4'b0000: w_dec_op = 3'b000;
            4'b0001: w_dec_op = 3'b010;
            4'b0010: w_dec_op = 3'b011;
            4'b0011: begin w_dec_op = 3'b100; w_dec_arith = 1'b1; end
            4'b0100: begin w_dec_op = 3'b100; w_dec_arith = 1'b1; w_dec_binv = 1'b1; end
            4'b0101: begin
                w_dec_op = 3'b100; w_dec_arith = 1'b1; w_dec_binv = 1'b1; w_dec_slt = 1'b1;
            end
            default: w_dec_invalid = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        o_slice_a       = 1'b0;
        o_slice_b       = 1'b0;
        o_slice_cin     = 1'b0;
        o_slice_ainvert = 1'b0;
        o_slice_binvert = 1'b0;
        o_slice_less    = 1'b0;
        o_slice_op      = 3'b000;
        case (r_state)
            S_IDLE: if (io_cpu.start) w_state_nxt = S_RUN;
            S_RUN: begin
                o_slice_a       = r_a_sh[0];
                o_slice_b       = r_b_sh[0] & ~r_invalid;
                o_slice_cin     = r_carry;
                o_slice_binvert = r_binv;
                o_slice_op      = r_slice_op;
                if (w_abort)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = r_is_slt ? S_SLT2 : S_DONE;
            end
            S_SLT2: begin
                o_slice_op   = 3'b101;
                o_slice_less = r_set && (r_cnt == '0);
                if (w_abort)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = io_cpu.start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---- bit-serial datapath: result collection, carry chain and flags ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_set       <= 1'b0;
            r_slice_op  <= 3'b000;
            r_binv      <= 1'b0;
            r_is_slt    <= 1'b0;
            r_arith     <= 1'b0;
            r_invalid   <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_carry     <= w_dec_binv;
            r_slice_op  <= w_dec_op;
            r_binv      <= w_dec_binv;
            r_is_slt    <= w_dec_slt;
            r_arith     <= w_dec_arith;
            r_invalid   <= w_dec_invalid;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_abort) begin
            r_invalid   <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_nxt;
            r_carry  <= i_slice_carry_out;
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                // carry into the MSB is r_carry; set = signed "less than" of the difference
                if (r_arith) begin
                    r_carry_out <= i_slice_carry_out;
                    r_overflow  <= r_carry ^ i_slice_carry_out;
                end
                r_set <= i_slice_result ^ r_carry ^ i_slice_carry_out;
                if (!r_is_slt) r_zero <= ~r_invalid && (w_result_nxt == '0);
            end
        end else if (r_state == S_SLT2) begin
            r_result <= w_result_nxt;
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) r_zero <= (w_result_nxt == '0);
        end
    end

    // Operand shift registers carry no control state, so they need no reset
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_a_sh <= io_cpu.op_a;
            r_b_sh <= io_cpu.op_b;
        end else if (r_state == S_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
        end
    end

    assign io_cpu.busy      = (r_state == S_RUN) || (r_state == S_SLT2);
    assign io_cpu.done      = (r_state == S_DONE);
    assign io_cpu.result    = r_result;
    assign io_cpu.carry_out = r_carry_out;
    assign io_cpu.overflow  = r_overflow;
    assign io_cpu.zero      = r_zero;
    assign io_cpu.invalid   = r_invalid;
endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq: behavioural 1-bit slice plus an
// arithmetic reference model; directed vectors followed by random operations.
`timescale 1ns/1ps
module tb_alu_bitserial_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_bitserial_seq_if #(.WIDTH(W)) bus ();

    logic       s_a, s_b, s_cin, s_ainv, s_binv, s_less, s_res, s_cout;
    logic [2:0] s_op;
    logic       sl_xa, sl_xb;

    alu_bitserial_seq #(.WIDTH(W)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .io_cpu            (bus),
        .o_slice_a         (s_a),
        .o_slice_b         (s_b),
        .o_slice_cin       (s_cin),
        .o_slice_ainvert   (s_ainv),
        .o_slice_binvert   (s_binv),
        .o_slice_less      (s_less),
        .o_slice_op        (s_op),
        .i_slice_result    (s_res),
        .i_slice_carry_out (s_cout)
    );

    // Classic 1-bit ALU slice
    always_comb begin
        sl_xa  = s_a ^ s_ainv;
        sl_xb  = s_b ^ s_binv;
        s_cout = (sl_xa & sl_xb) | (sl_xa & s_cin) | (sl_xb & s_cin);
        case (s_op)
            3'b000:  s_res = sl_xa & sl_xb;
            3'b010:  s_res = sl_xa | sl_xb;
            3'b011:  s_res = sl_xa ^ sl_xb;
            3'b100:  s_res = sl_xa ^ sl_xb ^ s_cin;
            3'b101:  s_res = s_less;
            default: s_res = 1'b0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    logic [W-1:0] e_res;
    logic         e_co, e_ov, e_z, e_inv;
    int           e_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-word arithmetic, no bit-serial detail
    task automatic predict(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        e_co = 1'b0; e_ov = 1'b0; e_inv = 1'b0; e_lat = W;
        case (c)
            4'd0: e_res = a & b;
            4'd1: e_res = a | b;
            4'd2: e_res = a ^ b;
            4'd3: begin
                s     = {1'b0, a} + {1'b0, b};
                e_res = s[W-1:0];
                e_co  = s[W];
                e_ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            4'd4, 4'd5: begin
                s     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e_co  = s[W];
                e_ov  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
                if (c == 4'd4) e_res = s[W-1:0];
                else begin
                    e_res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                    e_lat = 2 * W;
                end
            end
            default: begin e_res = '0; e_inv = 1'b1; end
        endcase
        e_z = !e_inv && (e_res == '0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic start_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        predict(c, a, b);
        bus.ctrl = c; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ctrl  = 4'($urandom);
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("done_after_accept", 32'(bus.done), 32'd0);
        check("result_cleared", 32'(bus.result), 32'd0);
        check("carry_cleared", 32'(bus.carry_out), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int start_cyc);
        int cyc;
        cyc = start_cyc;
        while (bus.done !== 1'b1 && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
        check({tag, "_result"}, 32'(bus.result), 32'(e_res));
        check({tag, "_carry"}, 32'(bus.carry_out), 32'(e_co));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(e_ov));
        check({tag, "_zero"}, 32'(bus.zero), 32'(e_z));
        check({tag, "_invalid"}, 32'(bus.invalid), 32'(e_inv));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_slice_op_done"}, 32'(s_op), 32'd0);
    endtask

    task automatic idle_after(input string tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_result_held"}, 32'(bus.result), 32'(e_res));
        check({tag, "_idle_slice_b"}, 32'({s_a, s_b, s_cin, s_binv, s_less}), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        start_op(c, a, b);
        wait_done(tag, 0);
        idle_after(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'd0);
        check({tag, "_flags"}, 32'({bus.carry_out, bus.overflow, bus.zero, bus.invalid}), 32'd0);
        check({tag, "_slice"}, 32'({s_a, s_b, s_cin, s_ainv, s_binv, s_less, s_op}), 32'd0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edges [4];
        edges[0] = '0; edges[1] = '1; edges[2] = W'(1) << (W - 1); edges[3] = ~(W'(1) << (W - 1));
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c;
        int         done_seen;
        bus.start = 1'b0; bus.ctrl = '0; bus.op_a = '0; bus.op_b = '0;
`ifdef ALU_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ovf", 4'd3, 16'h7FFF, 16'h0001);
        check("add_ovf_const", 32'({bus.result, bus.overflow, bus.carry_out}), 32'({16'h8000, 2'b10}));
        run_op("sub_neg", 4'd4, 16'h0005, 16'h0007);
        check("sub_neg_const", 32'(bus.result), 32'h0000FFFE);
        run_op("sub_zero", 4'd4, 16'h1234, 16'h1234);
        check("sub_zero_const", 32'({bus.zero, bus.carry_out}), 32'd3);

        // SLT with slice-drive probes in each pass
        start_op(4'd5, 16'h8000, 16'h0001);
        check("slt_p1_drive", 32'({s_op, s_binv, s_cin, s_less}), 32'b100_1_1_0);
        repeat (W) @(negedge clk);
        check("slt_p2_drive", 32'({s_op, s_binv, s_less}), 32'b101_0_1);
        wait_done("slt_true", W);
        check("slt_true_const", 32'(bus.result), 32'd1);
        idle_after("slt_true");
        run_op("slt_false", 4'd5, 16'h0001, 16'h8000);
        run_op("slt_ovf", 4'd5, 16'h7FFF, 16'hFFFF);
        check("slt_ovf_const", 32'(bus.result), 32'd0);

        run_op("and", 4'd0, 16'hF0F0, 16'hFF00);
        check("and_const", 32'(bus.result), 32'h0000F000);
        run_op("or", 4'd1, 16'hF0F0, 16'hFF00);
        check("or_const", 32'(bus.result), 32'h0000FFF0);
        run_op("xor", 4'd2, 16'hF0F0, 16'hFF00);
        check("xor_const", 32'(bus.result), 32'h00000FF0);
        run_op("invalid", 4'hF, 16'hF0F0, 16'hFF00);
        check("invalid_const", 32'({bus.result, bus.invalid}), 32'd1);

        // Start pulsed while busy is ignored
        start_op(4'd3, 16'h1111, 16'h2222);
        repeat (4) @(negedge clk);
        bus.ctrl = 4'd4; bus.op_a = 16'hAAAA; bus.op_b = 16'h5555; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start", 5);
        idle_after("busy_start");

        // Back-to-back: Start held in DONE
        start_op(4'd3, 16'h00FF, 16'h0F0F);
        wait_done("b2b_first", 0);
        start_op(4'd2, 16'h1357, 16'h2468);
        wait_done("b2b_second", 0);
        idle_after("b2b_second");

        // Reset mid-operation
        start_op(4'd3, 16'h1234, 16'h1111);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("midreset_no_done", 32'(done_seen), 32'd0);
        run_op("post_reset_add", 4'd3, 16'h0003, 16'h0004);
        check("post_reset_const", 32'(bus.result), 32'd7);

`ifdef ALU_SEQ_ABORT_EN
        start_op(4'd3, 16'h1234, 16'h4321);
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", 32'({bus.result, bus.carry_out, bus.overflow, bus.zero, bus.invalid}), 32'd0);
        done_seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 6));
            if (c == 4'd6) c = 4'($urandom_range(6, 15));
            start_op(c, pick_operand(), pick_operand());
            wait_done($sformatf("rand%0d", i), 0);
            if ($urandom_range(0, 1) == 0) idle_after($sformatf("rand%0d", i));
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2 * W + 4) @(negedge clk);
        check("final_idle", 32'({bus.busy, bus.done}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
